// File: rtl/panel_pkg.sv
// panel_pkg: constants shared between the front-panel renderer and the LED sampler.
//   LED vector layout (36 bits): addr[15:0], data[23:16], stat[31:24], other[35:32].
//   DEF_CNT_W / DEF_THRESH_SHIFT are the default counter width and duty-threshold shift.
package panel_pkg;
  localparam int N_ADDR  = 16;
  localparam int N_DATA  = 8;
  localparam int N_STAT  = 8;
  localparam int N_OTHER = 4;
  localparam int N_LED   = 36;

  localparam int OFS_ADDR  = 0;
  localparam int OFS_DATA  = 16;
  localparam int OFS_STAT  = 24;
  localparam int OFS_OTHER = 32;

  localparam int DEF_CNT_W        = 16;
  localparam int DEF_THRESH_SHIFT = 1;
endpackage

// File: rtl/led_duty_counter.sv
// led_duty_counter: one saturating per-LED on-counter plus the duty-threshold compare.
//   Only elaborated when PANEL_LED_DUTY_EN is defined (duty mode).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : frame boundary; the counter restarts from 0 on the next edge
//   inc_en     : a sample is taken this cycle (already gated by saturation)
//   lamp       : raw lamp value for this LED
//   smp_cnt    : registered frame sample count (without this cycle's sample)
//   lit        : threshold result including this cycle's sample
`ifdef PANEL_LED_DUTY_EN
module led_duty_counter #(
  parameter int CNT_W        = 16,
  parameter int THRESH_SHIFT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc_en,
  input  logic             lamp,
  input  logic [CNT_W-1:0] smp_cnt,
  output logic             lit
);
  // Compare width carries the shifted on-count without truncation.
  localparam int CMP_W = CNT_W + THRESH_SHIFT;

  logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
  logic [CNT_W-1:0] on_eff, smp_eff;
  logic [CMP_W-1:0] on_scaled, smp_ext;

  always_comb begin
    // Counts as they stand after this cycle's sample, so a sample on the
    // boundary cycle is part of the closing frame's decision.
    on_eff    = on_cnt_q + CNT_W'(inc_en & lamp);
    smp_eff   = smp_cnt + CNT_W'(inc_en);
    on_scaled = CMP_W'(on_eff) << THRESH_SHIFT;
    smp_ext   = CMP_W'(smp_eff);
    lit       = (on_scaled >= smp_ext) && (on_eff != '0);
    on_cnt_d  = clr ? '0 : on_eff;
  end

  always_ff @(posedge clk) begin
    if (reset) on_cnt_q <= '0;
    else       on_cnt_q <= on_cnt_d;
  end
endmodule
`endif

// File: rtl/panel_led_sampler.sv
// panel_led_sampler: samples CPU bus/status lamps on cpu_ce and updates the front-panel
// LED outputs only at frame boundaries (falling edge of active-low vga_vs).
// Build option PANEL_LED_DUTY_EN:
//   defined   : duty mode, LED lit if (on_cnt << THRESH_SHIFT) >= smp_cnt and on_cnt != 0
//   undefined : snapshot mode, LED = last sampled lamp value in the frame
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   cpu_ce                : sample strobe
//   cpu_addr/data/status/other : raw lamps (16/8/8/4)
//   vga_vs                : panel vsync, active-low
//   addrLEDs/dataLEDs/statusLEDs/otherLEDs : registered LED outputs
//   frame_tick            : one-cycle pulse in the cycle the LED outputs update
module panel_led_sampler
  import panel_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int THRESH_SHIFT = DEF_THRESH_SHIFT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_ce,
  input  logic [N_ADDR-1:0]  cpu_addr,
  input  logic [N_DATA-1:0]  cpu_data,
  input  logic [N_STAT-1:0]  cpu_status,
  input  logic [N_OTHER-1:0] cpu_other,
  input  logic               vga_vs,
  output logic [N_ADDR-1:0]  addrLEDs,
  output logic [N_DATA-1:0]  dataLEDs,
  output logic [N_STAT-1:0]  statusLEDs,
  output logic [N_OTHER-1:0] otherLEDs,
  output logic               frame_tick
);
  logic [N_LED-1:0] lamps;
  logic [N_LED-1:0] leds_q, leds_d;
  logic [N_LED-1:0] new_leds;
  logic             have_smp;
  logic             vs_q, vs_d;
  logic             armed_q, armed_d;
  logic             frame_tick_q, frame_tick_d;
  logic             bnd;

  assign lamps = {cpu_other, cpu_status, cpu_data, cpu_addr};

  // armed_q blocks boundaries until vga_vs has been seen high after reset, so a
  // vsync held low across reset release does not look like a falling edge.
  always_comb begin
    bnd          = vs_q & ~vga_vs & armed_q;
    vs_d         = vga_vs;
    armed_d      = armed_q | vga_vs;
    frame_tick_d = bnd;
    leds_d       = leds_q;
    if (bnd && have_smp) leds_d = new_leds;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q         <= 1'b1;
      armed_q      <= 1'b0;
      leds_q       <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      vs_q         <= vs_d;
      armed_q      <= armed_d;
      leds_q       <= leds_d;
      frame_tick_q <= frame_tick_d;
    end
  end

`ifdef PANEL_LED_DUTY_EN
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic             inc_en;
  logic [N_LED-1:0] lit_vec;

  // Once smp_cnt saturates every counter stops, preserving the duty ratio.
  always_comb begin
    inc_en    = cpu_ce & (smp_cnt_q != '1);
    smp_cnt_d = bnd ? '0 : smp_cnt_q + CNT_W'(inc_en);
    have_smp  = (smp_cnt_q != '0) | inc_en;
    new_leds  = lit_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) smp_cnt_q <= '0;
    else       smp_cnt_q <= smp_cnt_d;
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_led
    led_duty_counter #(
      .CNT_W        (CNT_W),
      .THRESH_SHIFT (THRESH_SHIFT)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr     (bnd),
      .inc_en  (inc_en),
      .lamp    (lamps[i]),
      .smp_cnt (smp_cnt_q),
      .lit     (lit_vec[i])
    );
  end
`else
  // The counter parameters have no effect here beyond sizing the seen flag;
  // a nonsensical parameter set collapses it to zero width and fails elaboration.
  localparam int SEEN_W = (CNT_W >= 1 && THRESH_SHIFT >= 0) ? 1 : 0;

  logic [N_LED-1:0]  shadow_q, shadow_d;
  logic [SEEN_W-1:0] seen_q, seen_d;

  // A sample on the boundary cycle bypasses the shadow so it still lands in
  // the closing frame.
  always_comb begin
    shadow_d = cpu_ce ? lamps : shadow_q;
    seen_d   = bnd ? '0 : (seen_q | SEEN_W'(cpu_ce));
    have_smp = seen_q[0] | cpu_ce;
    new_leds = cpu_ce ? lamps : shadow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      seen_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      seen_q   <= seen_d;
    end
  end
`endif

  assign addrLEDs   = leds_q[OFS_ADDR  +: N_ADDR];
  assign dataLEDs   = leds_q[OFS_DATA  +: N_DATA];
  assign statusLEDs = leds_q[OFS_STAT  +: N_STAT];
  assign otherLEDs  = leds_q[OFS_OTHER +: N_OTHER];
  assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_panel_led_sampler.sv
// Bench for panel_led_sampler. Two instances share all inputs: dut_m uses the default
// counter width, dut_s uses CNT_W=4 so saturation is reachable. Expected LED words
// ({other,stat,data,addr}) are queued at each boundary and popped on frame_tick.
module tb_panel_led_sampler;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic [7:0]  cpu_status;
  logic [3:0]  cpu_other;
  logic        vga_vs;

  logic [15:0] addr_m, addr_s;
  logic [7:0]  data_m, data_s, stat_m, stat_s;
  logic [3:0]  other_m, other_s;
  logic        tick_m, tick_s;
  logic [35:0] out_m, out_s;

  int checks = 0;
  int passed = 0;
  int ticks_m = 0;
  int ticks_s = 0;
  int pushes = 0;
  logic [35:0] exp_q[$];
  logic [35:0] exp_s_q[$];

  assign out_m = {other_m, stat_m, data_m, addr_m};
  assign out_s = {other_s, stat_s, data_s, addr_s};

  panel_led_sampler dut_m (
    .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_status(cpu_status), .cpu_other(cpu_other), .vga_vs(vga_vs),
    .addrLEDs(addr_m), .dataLEDs(data_m), .statusLEDs(stat_m), .otherLEDs(other_m),
    .frame_tick(tick_m)
  );

  panel_led_sampler #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_status(cpu_status), .cpu_other(cpu_other), .vga_vs(vga_vs),
    .addrLEDs(addr_s), .dataLEDs(data_s), .statusLEDs(stat_s), .otherLEDs(other_s),
    .frame_tick(tick_s)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // monitors: pop on each frame_tick
  always @(negedge clk) begin
    if (tick_m === 1'b1) begin
      ticks_m++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_tick_m: frame_tick=1 with leds %h, expected no tick", out_m);
      end else begin
        check("frame_leds_m", out_m, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (tick_s === 1'b1) begin
      ticks_s++;
      if (exp_s_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_tick_s: frame_tick=1 with leds %h, expected no tick", out_s);
      end else begin
        check("frame_leds_s", out_s, exp_s_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lamps(input logic [35:0] v);
    {cpu_other, cpu_status, cpu_data, cpu_addr} = v;
  endtask

  task automatic do_ce(input logic [35:0] v);
    set_lamps(v);
    cpu_ce = 1'b1;
    step();
    cpu_ce = 1'b0;
    set_lamps(36'h0);
  endtask

  // Falling vsync edge; optional ce on the boundary cycle and on bnd+1.
  task automatic boundary(input bit ce, input logic [35:0] v,
                          input logic [35:0] exp_m, input logic [35:0] exp_s,
                          input bit post_ce, input logic [35:0] pv);
    exp_q.push_back(exp_m);
    exp_s_q.push_back(exp_s);
    pushes++;
    vga_vs = 1'b0;
    if (ce) begin
      set_lamps(v);
      cpu_ce = 1'b1;
    end
    step();
    cpu_ce = 1'b0;
    set_lamps(36'h0);
    if (post_ce) do_ce(pv);
    else step();
    step();
    vga_vs = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] e_m;
    logic [35:0] e_s;
    reset  = 1'b1;
    cpu_ce = 1'b0;
    vga_vs = 1'b1;
    set_lamps(36'h0);
    repeat (3) step();
    check("reset_leds_m", out_m, 36'h0);
    check("reset_leds_s", out_s, 36'h0);
    check("reset_tick", {34'h0, tick_m, tick_s}, 36'h0);
    reset = 1'b0;
    repeat (2) step();

    // 1: empty frame, outputs stay 0, tick still pulses
    boundary(1'b0, 36'h0, 36'h0, 36'h0, 1'b0, 36'h0);

    // 2: addr[0] on 60/100, addr[1] on 40/100 (disjoint)
    for (int i = 0; i < 100; i++) do_ce((i % 5 < 3) ? 36'h1 : 36'h2);
`ifdef PANEL_LED_DUTY_EN
    e_m = 36'h1; e_s = 36'h1;
`else
    e_m = 36'h2; e_s = 36'h2;
`endif
    boundary(1'b0, 36'h0, e_m, e_s, 1'b0, 36'h0);

    // 3: only sample lands on the boundary cycle, then an empty frame holds it
    boundary(1'b1, 36'h0_00A5_0000, 36'h0_00A5_0000, 36'h0_00A5_0000, 1'b0, 36'h0);
    repeat (3) step();
    boundary(1'b0, 36'h0, 36'h0_00A5_0000, 36'h0_00A5_0000, 1'b0, 36'h0);

    // 4: 20 samples, status[7] always on, status[6] on for the last 10
    for (int i = 0; i < 20; i++) do_ce((i >= 10) ? 36'h0_C000_0000 : 36'h0_8000_0000);
`ifdef PANEL_LED_DUTY_EN
    e_m = 36'h0_C000_0000; e_s = 36'h0_8000_0000;
`else
    e_m = 36'h0_C000_0000; e_s = 36'h0_C000_0000;
`endif
    boundary(1'b0, 36'h0, e_m, e_s, 1'b0, 36'h0);
    for (int i = 0; i < 3; i++) do_ce(36'h0_0000_1234);
    boundary(1'b0, 36'h0, 36'h1234, 36'h1234, 1'b0, 36'h0);

    // 5: reset mid-frame after 50 all-on samples, vsync low across release
    for (int i = 0; i < 50; i++) do_ce(36'hF_FFFF_FFFF);
    reset = 1'b1;
    step();
    check("midreset_leds_m", out_m, 36'h0);
    check("midreset_leds_s", out_s, 36'h0);
    vga_vs = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    repeat (5) step();
    vga_vs = 1'b1;
    repeat (2) step();
    boundary(1'b0, 36'h0, 36'h0, 36'h0, 1'b0, 36'h0);

    // 6: back-to-back frames, second one sampled from bnd+1 onward
    for (int i = 0; i < 5; i++) do_ce(36'h00FF);
    boundary(1'b0, 36'h0, 36'h00FF, 36'h00FF, 1'b1, 36'hFF00);
    for (int i = 0; i < 2; i++) do_ce(36'hFF00);
    boundary(1'b0, 36'h0, 36'hFF00, 36'hFF00, 1'b0, 36'h0);

    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp_s_q.size() != 0); i++) step();
    check_int("pending_m", exp_q.size(), 0);
    check_int("pending_s", exp_s_q.size(), 0);
    check_int("tick_count_m", ticks_m, pushes);
    check_int("tick_count_s", ticks_s, pushes);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
